// File: rtl/alu_cmd_sequencer.sv
// Command sequencer feeding a registered 8-bit ALU: buffers commands, issues one at a time, returns results.
// Latency: issue edge to res_valid is ALU_LAT+1 cycles; handshake to res_valid is ALU_LAT+2 cycles when idle.
// Backpressure: cmd_ready drops when the FIFO is full; res_valid/res_data/res_zero hold while res_ready is low.
//
// Ports:
//   clk, rst_                  clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_opcode/cmd_a/cmd_b/cmd_use_acc carry the command
//   acc_clr                    synchronous accumulator clear (wins over a result capture)
//   alu_opcode/alu_a/alu_b     registered operands to the ALU; alu_out/alu_zero come back from it
//   res_valid/res_ready        result handshake; res_data/res_zero carry the captured result
//   acc                        accumulator (last captured result unless cleared)
//   busy                       FSM not idle or commands still queued
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_opcode,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  input  logic       acc_clr,
  output logic [2:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_zero,
  output logic [7:0] acc,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAT_ONE  = 1;
  localparam logic [CW-1:0] LAT_LOAD = CW'(ALU_LAT);

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic          issue;
  logic          capture;
  logic          res_done;

  // ---------------- command FIFO ----------------
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign pop       = issue;
  assign head      = mem[rd_ptr];

  // Storage needs no reset: entries are only read once the registered empty flag says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_t'{op: cmd_opcode, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};
    end
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_ONE;
    end else if (!push && pop) begin
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  // ---------------- sequencing FSM ----------------
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    capture  = 1'b0;
    res_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_valid && res_ready) begin
          res_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      cnt        <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_zero   <= 1'b0;
      acc        <= '0;
    end else begin
      if (issue) begin
        alu_opcode <= head.op;
        // acc is sampled as it stands at the issue edge, so chained commands see the previous result.
        alu_a      <= head.use_acc ? acc : head.a;
        alu_b      <= head.b;
        cnt        <= LAT_LOAD;
      end else if (state_q == S_WAIT && cnt != '0) begin
        cnt <= cnt - LAT_ONE;
      end

      if (capture) begin
        res_data  <= alu_out;
        res_zero  <= alu_zero;
        res_valid <= 1'b1;
      end else if (res_done) begin
        res_valid <= 1'b0;
      end

      // A clear wins over a simultaneous capture; res_data still gets the ALU value above.
      if (acc_clr) begin
        acc <= '0;
      end else if (capture) begin
        acc <= alu_out;
      end
    end
  end

  assign busy = (state_q != S_IDLE) | ~empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst_;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_use_acc;
  logic       acc_clr;
  logic [2:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       alu_zero;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_zero;
  logic [7:0] acc;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    logic       zero;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] acc_model;
  int         vectors;
  int         fails;
  int         res_seen;
  logic       rnd_done;

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst_(rst_),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .acc_clr(acc_clr),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
    .acc(acc), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 8-bit ALU with one register stage.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a ^ b;
      3'd3: return a | b;
      3'd4: return a & b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  initial alu_out = 8'h00;
  always @(posedge clk) alu_out <= alu_f(alu_opcode, alu_a, alu_b);
  assign alu_zero = (alu_out == 8'h00);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard consumer: one expected result per completed result handshake.
  always @(negedge clk) begin
    if (rst_ && res_valid) res_seen++;
    if (rst_ && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL unexpected_result: got %0h, required no result", res_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_data", {24'd0, res_data}, {24'd0, e.data});
        check("res_zero", {31'd0, res_zero}, {31'd0, e.zero});
      end
    end
  end

  // Called and returns at 1ns after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua);
    int   n;
    exp_t e;
    logic [7:0] r;
    n = 0;
    cmd_opcode  = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = ua;
    cmd_valid   = 1'b1;
    while (!cmd_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      vectors++;
      fails++;
      $display("FAIL send_timeout: got cmd_ready=0, required 1 within 300 cycles");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    r = alu_f(op, ua ? acc_model : a, b);
    e.data = r;
    e.zero = (r == 8'h00);
    exp_q.push_back(e);
    acc_model = r;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    res_ready = 1'b1;
    while ((busy || res_valid || exp_q.size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      vectors++;
      fails++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d, required idle", busy, exp_q.size());
    end
  endtask

  initial begin
    logic [2:0] op6 [6];
    logic [7:0] a6  [6];
    logic [7:0] b6  [6];
    logic       u6  [6];
    logic [7:0] held;

    vectors = 0; fails = 0; res_seen = 0; rnd_done = 1'b0;
    acc_model = 8'h00;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0;
    acc_clr = 1'b0; res_ready = 1'b0;
    rst_ = 1'b0;

    // Reset values
    #22;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_acc", {24'd0, acc}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu_a", {24'd0, alu_a}, 32'd0);
    rst_ = 1'b1;
    @(posedge clk); #1;

    // 1: single command latency
    send(3'd0, 8'h01, 8'h02, 1'b0);
    @(posedge clk); #1;
    check("t1_alu_a", {24'd0, alu_a}, 32'h01);
    check("t1_alu_b", {24'd0, alu_b}, 32'h02);
    check("t1_alu_op", {29'd0, alu_opcode}, 32'd0);
    check("t1_rv_c1", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    check("t1_rv_c2", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    check("t1_rv_c3", {31'd0, res_valid}, 32'd1);
    check("t1_acc", {24'd0, acc}, 32'h03);
    check("t1_busy", {31'd0, busy}, 32'd1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("t1_rv_drop", {31'd0, res_valid}, 32'd0);
    wait_idle();

    // 2: chained through accumulator
    send(3'd0, 8'h01, 8'h02, 1'b0);
    send(3'd0, 8'hFF, 8'h05, 1'b1);
    wait_idle();
    check("t2_alu_a", {24'd0, alu_a}, 32'h03);
    check("t2_alu_b", {24'd0, alu_b}, 32'h05);
    check("t2_acc", {24'd0, acc}, 32'h08);

    // 3: zero flag
    send(3'd1, 8'h04, 8'h04, 1'b0);
    send(3'd4, 8'h09, 8'h03, 1'b0);
    wait_idle();
    check("t3_acc", {24'd0, acc}, 32'h01);
    check("t3_busy", {31'd0, busy}, 32'd0);

    // 4: backpressure and full FIFO
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      op6[i] = 3'($urandom_range(0, 7));
      a6[i]  = 8'($urandom);
      b6[i]  = 8'($urandom);
      u6[i]  = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 5; i++) send(op6[i], a6[i], b6[i], u6[i]);
    held = exp_q[0].data;
    cmd_opcode = op6[5]; cmd_a = a6[5]; cmd_b = b6[5]; cmd_use_acc = u6[5];
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t4_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("t4_res_valid", {31'd0, res_valid}, 32'd1);
      check("t4_res_held", {24'd0, res_data}, {24'd0, held});
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    send(op6[5], a6[5], b6[5], u6[5]);
    wait_idle();

    // 5: acc_clr on the capture edge
    send(3'd3, 8'h01, 8'h02, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    acc_model = 8'h00;
    check("t5_acc_clr", {24'd0, acc}, 32'h00);
    check("t5_rv", {31'd0, res_valid}, 32'd1);
    send(3'd0, 8'($urandom), 8'h07, 1'b1);
    wait_idle();
    check("t5_acc", {24'd0, acc}, 32'h07);

    // 6: reset mid-WAIT with two commands queued
    send(3'd0, 8'h11, 8'h22, 1'b0);
    send(3'd0, 8'h33, 8'h44, 1'b0);
    send(3'd0, 8'h55, 8'h66, 1'b0);
    check("t6_busy_pre", {31'd0, busy}, 32'd1);
    rst_ = 1'b0;
    #1;
    check("t6_alu_op", {29'd0, alu_opcode}, 32'd0);
    check("t6_alu_a", {24'd0, alu_a}, 32'd0);
    check("t6_alu_b", {24'd0, alu_b}, 32'd0);
    check("t6_res_valid", {31'd0, res_valid}, 32'd0);
    check("t6_res_data", {24'd0, res_data}, 32'd0);
    check("t6_res_zero", {31'd0, res_zero}, 32'd0);
    check("t6_acc", {24'd0, acc}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    #1;
    rst_ = 1'b1;
    exp_q.delete();
    acc_model = 8'h00;
    res_seen = 0;
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_result", res_seen, 32'd0);
    check("t6_busy_post", {31'd0, busy}, 32'd0);
    check("t6_ready_post", {31'd0, cmd_ready}, 32'd1);

    // Random traffic with random result backpressure
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    wait_idle();
    check("rnd_acc", {24'd0, acc}, {24'd0, acc_model});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
